ex_muldiv_unit: RTL
===================

// Module: ex_muldiv_unit
// PURPOSE
//  Iterative RV32M multiply/divide unit attached to the Execute stage.
//  - Execute hands over M-extension ops (opcode R, funct7=0000001); it holds o_stall while the op iterates.
//  - Result returns with its rd for the EX/MEM register. Supports flush on branch redirect.
//  - Generalises the single-cycle ALU to a parametrised multi-cycle datapath.
// PARAMETERS
//  XLEN    32  operand/result width
//  UNROLL   1  bits retired per CALC cycle; legal values 1, 2, 4; must divide XLEN
// PORTS
//  clk           in   1     clock, rising edge
//  rst           in   1     synchronous reset, active high
//  i_valid       in   1     op request from Execute
//  i_func3       in   3     000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
//  i_rs1_data    in   XLEN  operand A, already forwarded (dividend)
//  i_rs2_data    in   XLEN  operand B, already forwarded (divisor)
//  i_rd          in   5     destination register
//  i_flush       in   1     kill the in-flight op
//  o_ready       out  1     1 only in IDLE
//  o_stall       out  1     pipeline hold request
//  o_valid       out  1     result valid, one-cycle pulse
//  o_result      out  XLEN  result
//  o_rd          out  5     rd of the result
// BEHAVIOUR
//  - Reset: state=IDLE; o_valid=0, o_result=0, o_rd=0, o_ready=1, o_stall=0; all internal regs cleared.
//  - FSM states: IDLE, CALC, DONE.
//    - IDLE->CALC: i_valid & !i_flush. Operands, func3 and rd are latched.
//    - IDLE->DONE: fast path instead of CALC when a special case applies (see below).
//    - CALC: down-counter starts at XLEN/UNROLL-1. CALC->DONE when count==0.
//    - DONE->IDLE: always, after one cycle.
//  - Latency: accept at edge N -> o_valid=1 during cycle N+XLEN/UNROLL+1. Fast path: o_valid during cycle N+1.
//  - o_stall = (IDLE & i_valid) | CALC. It is combinational in IDLE. It is low in DONE, so Execute advances on the o_valid cycle.
//  - o_result and o_rd are registered on DONE entry and hold their value until the next DONE.
//  - MUL: shift-add over a 2*XLEN product of operand magnitudes.
//    - Operand signedness: MULH both signed; MULHSU A signed, B unsigned; MULHU none.
//    - Product is negated at DONE if the signs differ.
//    - MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits.
//  - DIV/REM: restoring division on magnitudes.
//    - Quotient sign = sign(A)^sign(B). Remainder takes the sign of A.
//  - Special cases take the fast path in all builds:
//    - B==0: DIV/DIVU -> all ones; REM/REMU -> A.
//    - Signed overflow A=0x80000000, B=-1: DIV -> 0x80000000; REM -> 0.
//  - Flush: i_flush in any state -> IDLE next edge.
//    - o_valid stays 0 for the killed op; o_result/o_rd keep their old values.
//    - Flush beats a same-cycle i_valid, which is not accepted.
//  - i_valid while not IDLE is ignored. Execute must hold the request until o_stall drops.
//  - rst mid-op: behaves as reset; no o_valid is produced.
// CONFIGURATION
//  - Macro MULDIV_EARLY_OUT_EN.
//  - Defined: these conditions take the fast path (o_valid during cycle N+1):
//    - MUL* with an operand equal to zero: result 0.
//    - DIV*/REM* with |A| < |B|: quotient 0, remainder A.
//  - Undefined: only the B==0 and overflow cases are fast; all other ops take the full latency.
// TESTING
//  1. Reset: assert rst 2 cycles -> o_valid=0, o_result=0, o_rd=0, o_ready=1, o_stall=0.
//  2. MUL, A=7, B=-3, rd=5 -> o_stall high 33 cycles; o_valid in cycle N+33; o_result=0xFFFFFFEB, o_rd=5.
//  3. MULHU, A=B=0xFFFFFFFF -> o_result=0xFFFFFFFE. MULH with the same operands -> o_result=0.
//  4. DIV A=-7,B=2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF.
//     DIVU A=100,B=0 -> 0xFFFFFFFF in cycle N+1.
//     DIV A=0x80000000,B=-1 -> 0x80000000 in cycle N+1.
//  5. DIVU 1000/7 accepted; i_flush in CALC cycle 10 -> IDLE next edge, no o_valid.
//     A new DIVU 9/2 is then accepted -> o_result=4.
//  6. UNROLL=4: MUL 3*5 -> o_valid in cycle N+9, o_result=15.
//     With MULDIV_EARLY_OUT_EN: DIVU 3/5 -> o_result=0 in cycle N+1.

Source files
------------

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the Execute stage: shift-add multiply, restoring divide.
// Optional build macro MULDIV_EARLY_OUT_EN adds fast paths for zero multiplies and |A| < |B| divides.
module ex_muldiv_unit #(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_valid,
  input  logic [2:0]      i_func3,
  input  logic [XLEN-1:0] i_rs1_data,
  input  logic [XLEN-1:0] i_rs2_data,
  input  logic [4:0]      i_rd,
  input  logic            i_flush,
  output logic            o_ready,
  output logic            o_stall,
  output logic            o_valid,
  output logic [XLEN-1:0] o_result,
  output logic [4:0]      o_rd
);
  localparam int STEPS = XLEN / UNROLL;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state_reg;
  logic [CNT_W-1:0] count_reg;
  logic [2:0]      func3_reg;
  logic [4:0]      rd_reg;
  logic [XLEN-1:0] acc_reg, lo_reg, opd_reg;
  logic            neg_reg;
  logic            valid_reg;
  logic [XLEN-1:0] result_reg;
  logic [4:0]      rd_out_reg;

  logic            in_div, sgn_a, sgn_b, neg_a, neg_b, b_zero, ovf, fast_take;
  logic [XLEN-1:0] mag_a, mag_b, fast_result;

  assign in_div = i_func3[2];
  assign sgn_a  = in_div ? ~i_func3[0] : (i_func3[1] ^ i_func3[0]);
  assign sgn_b  = in_div ? ~i_func3[0] : (i_func3[1:0] == 2'b01);
  assign neg_a  = sgn_a & i_rs1_data[XLEN-1];
  assign neg_b  = sgn_b & i_rs2_data[XLEN-1];
  assign mag_a  = neg_a ? -i_rs1_data : i_rs1_data;
  assign mag_b  = neg_b ? -i_rs2_data : i_rs2_data;
  assign b_zero = (i_rs2_data == '0);
  assign ovf    = in_div & ~i_func3[0] & (i_rs1_data == MIN_NEG) & (&i_rs2_data);

  // Results known without iterating; func3[1] selects REM over DIV.
  always_comb begin
    fast_take   = 1'b0;
    fast_result = '0;
    if (in_div && b_zero) begin
      fast_take   = 1'b1;
      fast_result = i_func3[1] ? i_rs1_data : '1;
    end else if (ovf) begin
      fast_take   = 1'b1;
      fast_result = i_func3[1] ? '0 : i_rs1_data;
    end
`ifdef MULDIV_EARLY_OUT_EN
    else if (!in_div && (i_rs1_data == '0 || b_zero)) begin
      fast_take   = 1'b1;
      fast_result = '0;
    end else if (in_div && (mag_a < mag_b)) begin
      fast_take   = 1'b1;
      fast_result = i_func3[1] ? i_rs1_data : '0;
    end
`endif
  end

  // UNROLL chained single-bit steps; acc holds product-high / remainder, lo holds multiplier / quotient.
  logic [XLEN-1:0] acc_chain [UNROLL+1];
  logic [XLEN-1:0] lo_chain  [UNROLL+1];
  assign acc_chain[0] = acc_reg;
  assign lo_chain[0]  = lo_reg;

  for (genvar gi = 0; gi < UNROLL; gi++) begin : g_stage
    logic [XLEN:0] mul_sum, div_shift, div_diff;
    logic          div_ge;
    assign mul_sum   = {1'b0, acc_chain[gi]} + (lo_chain[gi][0] ? {1'b0, opd_reg} : '0);
    assign div_shift = {acc_chain[gi], lo_chain[gi][XLEN-1]};
    assign div_diff  = div_shift - {1'b0, opd_reg};
    assign div_ge    = ~div_diff[XLEN];
    assign acc_chain[gi+1] = func3_reg[2] ? (div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0])
                                          : mul_sum[XLEN:1];
    assign lo_chain[gi+1]  = func3_reg[2] ? {lo_chain[gi][XLEN-2:0], div_ge}
                                          : {mul_sum[0], lo_chain[gi][XLEN-1:1]};
  end

  logic [2*XLEN-1:0] prod, prod_signed;
  logic [XLEN-1:0]   div_mag, div_signed, calc_result;

  assign prod        = {acc_chain[UNROLL], lo_chain[UNROLL]};
  assign prod_signed = neg_reg ? -prod : prod;
  assign div_mag     = func3_reg[1] ? acc_chain[UNROLL] : lo_chain[UNROLL];
  assign div_signed  = neg_reg ? -div_mag : div_mag;

  always_comb begin
    calc_result = prod_signed[2*XLEN-1:XLEN];
    if (func3_reg[2])
      calc_result = div_signed;
    else if (func3_reg[1:0] == 2'b00)
      calc_result = prod_signed[XLEN-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      count_reg  <= '0;
      func3_reg  <= '0;
      rd_reg     <= '0;
      acc_reg    <= '0;
      lo_reg     <= '0;
      opd_reg    <= '0;
      neg_reg    <= 1'b0;
      valid_reg  <= 1'b0;
      result_reg <= '0;
      rd_out_reg <= '0;
    end else begin
      valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (i_valid && !i_flush) begin
            func3_reg <= i_func3;
            rd_reg    <= i_rd;
            neg_reg   <= (in_div && i_func3[1]) ? neg_a : (neg_a ^ neg_b);
            acc_reg   <= '0;
            lo_reg    <= in_div ? mag_a : mag_b;
            opd_reg   <= in_div ? mag_b : mag_a;
            count_reg <= CNT_W'(STEPS - 1);
            if (fast_take) begin
              state_reg  <= DONE;
              valid_reg  <= 1'b1;
              result_reg <= fast_result;
              rd_out_reg <= i_rd;
            end else begin
              state_reg <= CALC;
            end
          end
        end
        CALC: begin
          if (i_flush) begin
            state_reg <= IDLE;
          end else begin
            acc_reg   <= acc_chain[UNROLL];
            lo_reg    <= lo_chain[UNROLL];
            count_reg <= count_reg - CNT_W'(1);
            if (count_reg == '0) begin
              state_reg  <= DONE;
              valid_reg  <= 1'b1;
              result_reg <= calc_result;
              rd_out_reg <= rd_reg;
            end
          end
        end
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign o_ready  = (state_reg == IDLE);
  assign o_stall  = ((state_reg == IDLE) & i_valid) | (state_reg == CALC);
  assign o_valid  = valid_reg;
  assign o_result = result_reg;
  assign o_rd     = rd_out_reg;
endmodule
